// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch-stage program counter with reset/trap vectors,
// branch/jump redirects, a fetch-valid qualifier and misaligned-target flag.
// Optional return-address stack enabled by defining PC_RAS_EN; without it
// CallF/RetF are ignored and RasEmptyF is tied high.
module pc_fetch_unit #(
    parameter int unsigned          WIDTH        = 32,
    parameter logic [WIDTH-1:0]     RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0]     TRAP_VECTOR  = WIDTH'(32'h0000_0100),
    parameter int unsigned          RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallF,
    input  logic             RedirectE,
    input  logic [WIDTH-1:0] TargetE,
    input  logic             TrapE,
    input  logic             CallF,
    input  logic             RetF,
    output logic [WIDTH-1:0] PCF,
    output logic [WIDTH-1:0] PCPlus4F,
    output logic             ValidF,
    output logic             MisalignF,
    output logic             RasEmptyF
);

    logic [WIDTH-1:0] pc_q;
    logic             valid_q;
    logic             misalign_q;
    logic [WIDTH-1:0] pc_plus4;

    assign pc_plus4  = pc_q + WIDTH'(4);
    assign PCF       = pc_q;
    assign PCPlus4F  = pc_plus4;
    assign ValidF    = valid_q;
    assign MisalignF = misalign_q;

`ifdef PC_RAS_EN
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] top_idx;
    logic [CNT_W-1:0] cnt_q;
    logic             ras_has;
    logic             accept;

    // ptr_q is the next write slot; the top entry sits one below it
    assign top_idx   = ptr_q - PTR_W'(1);
    assign ras_has   = (cnt_q != '0);
    assign RasEmptyF = ~ras_has;
    // CallF/RetF belong to a live, unstalled instruction only
    assign accept    = valid_q & ~StallF & ~TrapE & ~RedirectE;

    // Return-address stack: push, pop, or replace-top on call+return
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            if (CallF && RetF && ras_has) begin
                ras_mem[top_idx] <= pc_plus4;
            end else if (CallF) begin
                ras_mem[ptr_q] <= pc_plus4;
                ptr_q          <= ptr_q + PTR_W'(1);
                if (cnt_q != CNT_W'(RAS_DEPTH))
                    cnt_q <= cnt_q + CNT_W'(1);
            end else if (RetF && ras_has) begin
                ptr_q <= top_idx;
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end
`else
    logic unused_ras_inputs;

    assign unused_ras_inputs = &{1'b0, CallF, RetF};
    assign RasEmptyF         = 1'b1;
`endif

    // Next-PC selection in priority order; MisalignF pulses for one edge only
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_VECTOR;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            if (TrapE) begin
                pc_q <= TRAP_VECTOR;
            end else if (RedirectE) begin
                pc_q       <= {TargetE[WIDTH-1:2], 2'b00};
                misalign_q <= (TargetE[1:0] != 2'b00);
            end else if (!valid_q) begin
                valid_q <= 1'b1;
            end else if (!StallF) begin
`ifdef PC_RAS_EN
                if (RetF && ras_has)
                    pc_q <= ras_mem[top_idx];
                else
                    pc_q <= pc_plus4;
`else
                pc_q <= pc_plus4;
`endif
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a stimulus process drives directed and
// random traffic and queues the expected outputs from a queue-based model;
// a monitor pops and compares after every rising edge.
module tb_pc_fetch_unit;

    localparam int unsigned W  = 16;
    localparam logic [W-1:0] RV = 16'h1000;
    localparam logic [W-1:0] TV = 16'h0100;
    localparam int unsigned  RD = 4;

    logic         clk = 1'b0;
    logic         rst, StallF, RedirectE, TrapE, CallF, RetF;
    logic [W-1:0] TargetE;
    logic [W-1:0] PCF, PCPlus4F;
    logic         ValidF, MisalignF, RasEmptyF;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .WIDTH(W),
        .RESET_VECTOR(RV),
        .TRAP_VECTOR(TV),
        .RAS_DEPTH(RD)
    ) dut (
        .clk(clk), .rst(rst), .StallF(StallF), .RedirectE(RedirectE),
        .TargetE(TargetE), .TrapE(TrapE), .CallF(CallF), .RetF(RetF),
        .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidF(ValidF),
        .MisalignF(MisalignF), .RasEmptyF(RasEmptyF)
    );

    typedef struct {
        logic [W-1:0] pc;
        logic [W-1:0] p4;
        logic         v;
        logic         m;
        logic         e;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // reference model state
    logic [W-1:0] m_pc;
    logic         m_valid, m_mis;
    logic [W-1:0] m_ras[$];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    // One cycle of stimulus: drive on the falling edge, advance the model,
    // queue what the DUT must show after the next rising edge.
    task automatic step(input logic r, input logic tr, input logic rd, input logic [W-1:0] tg,
                        input logic st, input logic ca, input logic re);
        exp_t e;
        logic [W-1:0] top;
        @(negedge clk);
        rst = r; TrapE = tr; RedirectE = rd; TargetE = tg; StallF = st; CallF = ca; RetF = re;
        if (r) begin
            m_pc = RV; m_valid = 1'b0; m_mis = 1'b0; m_ras.delete();
        end else begin
            m_mis = 1'b0;
            if (tr) m_pc = TV;
            else if (rd) begin
                m_pc  = tg & ~W'(3);
                m_mis = (tg % 4) != 0;
            end else if (!m_valid) m_valid = 1'b1;
            else if (!st) begin
`ifdef PC_RAS_EN
                if (re && m_ras.size() > 0) begin
                    top = m_ras[$];
                    if (ca) m_ras[m_ras.size()-1] = m_pc + 4;
                    else void'(m_ras.pop_back());
                    m_pc = top;
                end else begin
                    if (ca) begin
                        m_ras.push_back(m_pc + 4);
                        if (m_ras.size() > RD) m_ras.delete(0);
                    end
                    m_pc = m_pc + 4;
                end
`else
                m_pc = m_pc + 4;
`endif
            end
        end
        e.pc = m_pc; e.p4 = m_pc + 4; e.v = m_valid; e.m = m_mis;
        e.e  = (m_ras.size() == 0);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0, 0);
    endtask

    task automatic jump(input logic [W-1:0] t);
        step(0, 0, 1, t, 0, 0, 0);
    endtask

    // Monitor: compare every queued expectation just after the rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("PCF", PCF, e.pc);
                chk("PCPlus4F", PCPlus4F, e.p4);
                chk("ValidF", W'(ValidF), W'(e.v));
                chk("MisalignF", W'(MisalignF), W'(e.m));
                chk("RasEmptyF", W'(RasEmptyF), W'(e.e));
            end
        end
    end

    initial begin
        rst = 1'b1; StallF = 0; RedirectE = 0; TargetE = '0; TrapE = 0; CallF = 0; RetF = 0;
        m_pc = RV; m_valid = 0; m_mis = 0;

        // reset and first fetch
        for (int i = 0; i < 3; i++) step(1, 0, 0, '0, 0, 0, 0);
        idle(2);

        // stall, then redirect under stall with misaligned target
        jump(16'h0020);
        for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 1, 0, 0);
        step(0, 0, 1, 16'h0082, 1, 0, 0);
        step(0, 0, 0, '0, 1, 0, 0);
        step(0, 0, 0, '0, 1, 0, 0);
        idle(1);

        // trap beats redirect; wrap at the top of the address space
        step(0, 1, 1, 16'h0444, 0, 0, 0);
        jump(16'hFFFC);
        idle(2);

        // calls and returns
        jump(16'h0100); step(0, 0, 0, '0, 0, 1, 0);
        jump(16'h0200); step(0, 0, 0, '0, 0, 1, 0);
        jump(16'h0300);
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 0, 0, 1);

        // overflow: five pushes into four entries, then five pops
        for (int i = 1; i <= 5; i++) begin
            jump(W'(i * 16 - 4));
            step(0, 0, 0, '0, 0, 1, 0);
        end
        jump(16'h0800);
        for (int i = 0; i < 5; i++) step(0, 0, 0, '0, 0, 0, 1);

        // squashed call, call+return combos, stalled call, reset when full
        step(0, 0, 1, 16'h0900, 0, 1, 0);
        step(0, 0, 0, '0, 0, 1, 1);
        step(0, 0, 0, '0, 0, 1, 1);
        step(0, 0, 0, '0, 1, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 0, 1, 0);
        step(1, 0, 0, '0, 0, 0, 0);
        idle(2);
        step(0, 0, 0, '0, 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(99) == 0), ($urandom_range(19) == 0), ($urandom_range(7) == 0),
                 W'($urandom), ($urandom_range(3) == 0), ($urandom_range(4) == 0),
                 ($urandom_range(4) == 0));
        end
        idle(1);

        // let the monitor drain, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
